// File: rtl/decode_core.sv
// decode_core: decode-stage core of the 5-stage MIPS pipeline.
// It holds a 32x32 register file with write-through reads, the main control
// decoder and a load-use stall detector. The ID/EX register lives in the
// enclosing decode stage.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset; clears every register
//   instr        instruction from IF/ID
//   wr_en        write-back enable (WB RegWrite)
//   wr_addr      write-back register number
//   wr_data      write-back data
//   show_sel     debug register select
//   show_data    debug read of register show_sel
//   ex_memread   MemRead of the instruction now in ID/EX
//   ex_rt        rt field of the instruction now in ID/EX
//   rs_data      regs[instr[25:21]]
//   rt_data      regs[instr[20:16]]
//   RegDst, Jump, ALUsrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite,
//   ALUop[1:0]   control word, forced to zero while stalling
//   stall        load-use hazard: hold PC and IF/ID and insert a bubble
module decode_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] show_sel,
  output logic [DATA_W-1:0] show_data,
  input  logic              ex_memread,
  input  logic [ADDR_W-1:0] ex_rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              RegDst,
  output logic              Jump,
  output logic              ALUsrc,
  output logic              MemtoReg,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic              RegWrite,
  output logic [1:0]        ALUop,
  output logic              stall
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_J     = 6'b000010
  } opcode_t;

  logic [DATA_W-1:0] regs [2**ADDR_W];

  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [5:0]        opcode;
  logic              wr_live;
  logic              unused_instr;

  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign opcode  = instr[31:26];

  // Immediate/function bits are not needed by this stage.
  assign unused_instr = ^instr[15:0];

  // A write that will commit at the next edge; reads of the same register
  // see it now so WB -> ID needs no half-cycle register-file trick.
  assign wr_live = rst && wr_en && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs_data = '0;
    if (rs_addr != '0) begin
      rs_data = (wr_live && wr_addr == rs_addr) ? wr_data : regs[rs_addr];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt_addr != '0) begin
      rt_data = (wr_live && wr_addr == rt_addr) ? wr_data : regs[rt_addr];
    end
  end

  always_comb begin
    show_data = '0;
    if (show_sel != '0) begin
      show_data = (wr_live && wr_addr == show_sel) ? wr_data : regs[show_sel];
    end
  end

  assign stall = ex_memread && (ex_rt != '0) &&
                 ((ex_rt == rs_addr) || (ex_rt == rt_addr));

  always_comb begin
    RegDst   = 1'b0;
    Jump     = 1'b0;
    ALUsrc   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    ALUop    = 2'b00;
    if (!stall) begin
      case (opcode)
        OP_RTYPE: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          ALUop    = 2'b10;
        end
        OP_LW: begin
          ALUsrc   = 1'b1;
          MemtoReg = 1'b1;
          MemRead  = 1'b1;
          RegWrite = 1'b1;
        end
        OP_SW: begin
          ALUsrc   = 1'b1;
          MemWrite = 1'b1;
        end
        OP_BEQ: begin
          Branch = 1'b1;
          ALUop  = 2'b01;
        end
        OP_ADDI: begin
          ALUsrc   = 1'b1;
          RegWrite = 1'b1;
        end
        OP_J: begin
          Jump = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_core.sv
module tb_decode_core;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  show_sel;
  logic [31:0] show_data;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        RegDst, Jump, ALUsrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite;
  logic [1:0]  ALUop;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  // {RegDst,Jump,ALUsrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUop}
  logic [9:0] ctrl;
  assign ctrl = {RegDst, Jump, ALUsrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUop};

  decode_core #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .show_sel   (show_sel),
    .show_data  (show_data),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .RegDst     (RegDst),
    .Jump       (Jump),
    .ALUsrc     (ALUsrc),
    .MemtoReg   (MemtoReg),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Branch     (Branch),
    .RegWrite   (RegWrite),
    .ALUop      (ALUop),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    bit bad;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    instr = rtype(5'd1, 5'd2, 5'd3);
    #1;
    bad = 1'b0;
    for (int i = 0; i < 32; i++) begin
      show_sel = 5'(i);
      #1;
      if (show_data !== 32'h0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      $display("FAIL reset_regs: some register nonzero during reset, required all 0");
      n_fail++;
    end
    n_checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      $display("FAIL reset_operands: rs=%h rt=%h, required 0/0", rs_data, rt_data);
      n_fail++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctrl !== 10'b1000000110 || stall !== 1'b0) begin
      $display("FAIL reset_ctrl: ctrl=%b stall=%b, required 1000000110 0", ctrl, stall);
      n_fail++;
    end
  endtask

  task automatic test_write_read;
    do_write(5'd3, 32'h12345678);
    instr    = rtype(5'd3, 5'd0, 5'd1);
    show_sel = 5'd3;
    #1;
    n_checks++;
    if (rs_data !== 32'h12345678) begin
      $display("FAIL write_read_rs: got %h, required 12345678", rs_data);
      n_fail++;
    end
    n_checks++;
    if (show_data !== 32'h12345678) begin
      $display("FAIL write_read_show: got %h, required 12345678", show_data);
      n_fail++;
    end
    n_checks++;
    if (rt_data !== 32'h0) begin
      $display("FAIL read_r0_rt: got %h, required 0", rt_data);
      n_fail++;
    end
  endtask

  task automatic test_r0;
    instr   = rtype(5'd0, 5'd0, 5'd1);
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    #1;
    n_checks++;
    if (rs_data !== 32'h0) begin
      $display("FAIL r0_no_bypass: got %h, required 0", rs_data);
      n_fail++;
    end
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    show_sel = 5'd0;
    #1;
    n_checks++;
    if (rs_data !== 32'h0 || show_data !== 32'h0) begin
      $display("FAIL r0_write_ignored: rs=%h show=%h, required 0/0", rs_data, show_data);
      n_fail++;
    end
  endtask

  task automatic test_bypass;
    instr    = rtype(5'd3, 5'd7, 5'd1);
    show_sel = 5'd7;
    wr_en    = 1'b1;
    wr_addr  = 5'd7;
    wr_data  = 32'hA5A5A5A5;
    #1;
    n_checks++;
    if (rt_data !== 32'hA5A5A5A5 || show_data !== 32'hA5A5A5A5 || rs_data !== 32'h12345678) begin
      $display("FAIL bypass_pre_edge: rt=%h show=%h rs=%h, required a5a5a5a5 a5a5a5a5 12345678",
               rt_data, show_data, rs_data);
      n_fail++;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (rt_data !== 32'hA5A5A5A5) begin
      $display("FAIL bypass_committed: got %h, required a5a5a5a5", rt_data);
      n_fail++;
    end
    // same register on all three read ports
    instr    = rtype(5'd7, 5'd7, 5'd1);
    #1;
    n_checks++;
    if (rs_data !== 32'hA5A5A5A5 || rt_data !== 32'hA5A5A5A5 || show_data !== 32'hA5A5A5A5) begin
      $display("FAIL same_reg_all_ports: rs=%h rt=%h show=%h, required a5a5a5a5 x3",
               rs_data, rt_data, show_data);
      n_fail++;
    end
  endtask

  task automatic test_decode;
    logic [5:0] ops [9];
    logic [9:0] exp [9];
    ops[0] = 6'b000000; exp[0] = 10'b1000000110;
    ops[1] = 6'b100011; exp[1] = 10'b0011100100;
    ops[2] = 6'b101011; exp[2] = 10'b0010010000;
    ops[3] = 6'b000100; exp[3] = 10'b0000001001;
    ops[4] = 6'b001000; exp[4] = 10'b0010000100;
    ops[5] = 6'b000010; exp[5] = 10'b0100000000;
    ops[6] = 6'b111111; exp[6] = 10'b0000000000;
    ops[7] = 6'b001001; exp[7] = 10'b0000000000;
    ops[8] = 6'b100000; exp[8] = 10'b0000000000;
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
    for (int i = 0; i < 9; i++) begin
      instr = {ops[i], 5'd1, 5'd2, 16'h1234};
      #1;
      n_checks++;
      if (ctrl !== exp[i] || stall !== 1'b0) begin
        $display("FAIL decode_op_%b: ctrl=%b stall=%b, required %b 0", ops[i], ctrl, stall, exp[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_stall;
    do_write(5'd4, 32'h0BADF00D);
    ex_memread = 1'b1;
    ex_rt      = 5'd4;
    instr      = rtype(5'd4, 5'd2, 5'd1);
    #1;
    n_checks++;
    if (stall !== 1'b1 || ctrl !== 10'b0) begin
      $display("FAIL stall_rs: stall=%b ctrl=%b, required 1 0000000000", stall, ctrl);
      n_fail++;
    end
    n_checks++;
    if (rs_data !== 32'h0BADF00D) begin
      $display("FAIL stall_operand: rs=%h, required 0badf00d", rs_data);
      n_fail++;
    end
    instr = {6'b100011, 5'd2, 5'd4, 16'h0008};
    #1;
    n_checks++;
    if (stall !== 1'b1 || ctrl !== 10'b0) begin
      $display("FAIL stall_rt: stall=%b ctrl=%b, required 1 0000000000", stall, ctrl);
      n_fail++;
    end
    // write-back in a stall cycle still commits
    do_write(5'd9, 32'hCAFE0009);
    show_sel = 5'd9;
    #1;
    n_checks++;
    if (show_data !== 32'hCAFE0009 || stall !== 1'b1) begin
      $display("FAIL stall_writeback: show=%h stall=%b, required cafe0009 1", show_data, stall);
      n_fail++;
    end
  endtask

  task automatic test_no_stall;
    ex_memread = 1'b1;
    ex_rt      = 5'd0;
    instr      = rtype(5'd0, 5'd0, 5'd1);
    #1;
    n_checks++;
    if (stall !== 1'b0 || ctrl !== 10'b1000000110) begin
      $display("FAIL nostall_rt0: stall=%b ctrl=%b, required 0 1000000110", stall, ctrl);
      n_fail++;
    end
    ex_memread = 1'b0;
    ex_rt      = 5'd4;
    instr      = rtype(5'd4, 5'd4, 5'd1);
    #1;
    n_checks++;
    if (stall !== 1'b0 || ctrl !== 10'b1000000110) begin
      $display("FAIL nostall_nomemread: stall=%b ctrl=%b, required 0 1000000110", stall, ctrl);
      n_fail++;
    end
    ex_memread = 1'b1;
    ex_rt      = 5'd4;
    instr      = {6'b100011, 5'd5, 5'd6, 16'h0004};
    #1;
    n_checks++;
    if (stall !== 1'b0 || ctrl !== 10'b0011100100) begin
      $display("FAIL nostall_nomatch: stall=%b ctrl=%b, required 0 0011100100", stall, ctrl);
      n_fail++;
    end
    ex_memread = 1'b0;
    ex_rt      = 5'd0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    vals[0] = 32'h11110010;
    vals[1] = 32'h22220011;
    vals[2] = 32'h33330012;
    vals[3] = 32'h44440013;
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(10 + i);
      wr_data = vals[i];
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    instr = rtype(5'd10, 5'd11, 5'd1);
    #1;
    n_checks++;
    if (rs_data !== vals[0] || rt_data !== vals[1]) begin
      $display("FAIL b2b_r10_r11: rs=%h rt=%h, required %h %h", rs_data, rt_data, vals[0], vals[1]);
      n_fail++;
    end
    instr = rtype(5'd12, 5'd13, 5'd1);
    #1;
    n_checks++;
    if (rs_data !== vals[2] || rt_data !== vals[3]) begin
      $display("FAIL b2b_r12_r13: rs=%h rt=%h, required %h %h", rs_data, rt_data, vals[2], vals[3]);
      n_fail++;
    end
  endtask

  task automatic test_reset_midop;
    do_write(5'd5, 32'hDEADBEEF);
    show_sel = 5'd5;
    instr    = rtype(5'd3, 5'd9, 5'd1);
    #1;
    n_checks++;
    if (show_data !== 32'hDEADBEEF) begin
      $display("FAIL midreset_pre: show=%h, required deadbeef", show_data);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (show_data !== 32'h0 || rs_data !== 32'h0 || rt_data !== 32'h0) begin
      $display("FAIL midreset_async: show=%h rs=%h rt=%h, required 0 0 0", show_data, rs_data, rt_data);
      n_fail++;
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (show_data !== 32'h0) begin
      $display("FAIL midreset_after_release: show=%h, required 0", show_data);
      n_fail++;
    end
  endtask

  initial begin
    rst        = 1'b0;
    instr      = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    show_sel   = '0;
    ex_memread = 1'b0;
    ex_rt      = '0;

    test_reset;
    test_write_read;
    test_r0;
    test_bypass;
    test_decode;
    test_stall;
    test_no_stall;
    test_back_to_back;
    test_reset_midop;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
